// File: rtl/prog_mem.sv
// prog_mem: loadable program store for a small sequencer.
// A program is streamed in word by word (EMPTY -> LOAD -> RUN). Once in RUN,
// the store answers one fetch per cycle with a fixed one-cycle latency.
// Fetches at or beyond the loaded length return NOP and raise oob_o.
module prog_mem #(
  parameter int                 W_INST = 28,
  parameter int                 A      = 4,
  parameter logic [W_INST-1:0]  NOP    = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_valid_i,
  input  logic [W_INST-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              reload_i,
  input  logic              fetch_i,
  input  logic [A-1:0]      addr_i,
  output logic [W_INST-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              oob_o,
  output logic [A:0]        prog_len_o,
  output logic              running_o
);

  localparam int DEPTH = 1 << A;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [A-1:0]      wr_ptr_reg;
  logic [A:0]        prog_len_reg;

  logic [W_INST-1:0] mem [DEPTH];
  logic [W_INST-1:0] rd_data_reg;
  // Selects NOP instead of the RAM output; held between fetches so inst_o
  // keeps showing whatever the last fetch (or reset) produced.
  logic              nop_sel_reg;
  logic              inst_valid_reg;
  logic              oob_reg;

  logic              is_run;
  logic              ld_accept;
  logic              ld_is_last;
  logic              fetch_go;
  logic              fetch_oob;

  assign is_run     = (state_reg == ST_RUN);
  // A reload (or reset) in the same cycle wins: the presented word is dropped.
  assign ld_accept  = ld_valid_i & ~is_run & ~reload_i & ~rst_i;
  // The top slot always ends the program, so wr_ptr never wraps onto data.
  assign ld_is_last = ld_last_i | (wr_ptr_reg == {A{1'b1}});
  // A fetch coinciding with reload is still served from current contents.
  assign fetch_go   = fetch_i & is_run & ~rst_i;
  assign fetch_oob  = ({1'b0, addr_i} >= prog_len_reg);

  // Storage write port and registered read port; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (ld_accept) begin
      mem[wr_ptr_reg] <= ld_data_i;
    end
    if (fetch_go) begin
      rd_data_reg <= mem[addr_i];
    end
  end

  // Load/run state machine with write pointer and program length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_EMPTY;
      wr_ptr_reg   <= '0;
      prog_len_reg <= '0;
    end else if (reload_i) begin
      state_reg    <= ST_EMPTY;
      wr_ptr_reg   <= '0;
      prog_len_reg <= '0;
    end else if (ld_accept) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (ld_is_last) begin
        state_reg    <= ST_RUN;
        prog_len_reg <= {1'b0, wr_ptr_reg} + 1'b1;
      end else begin
        state_reg <= ST_LOAD;
      end
    end
  end

  // Fetch response flags: valid/oob pulse for one cycle per served fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nop_sel_reg    <= 1'b1;
      inst_valid_reg <= 1'b0;
      oob_reg        <= 1'b0;
    end else begin
      inst_valid_reg <= fetch_go;
      oob_reg        <= fetch_go & fetch_oob;
      if (fetch_go) begin
        nop_sel_reg <= fetch_oob;
      end
    end
  end

  assign ld_ready_o   = ~is_run;
  assign inst_o       = nop_sel_reg ? NOP : rd_data_reg;
  assign inst_valid_o = inst_valid_reg;
  assign oob_o        = oob_reg;
  assign prog_len_o   = prog_len_reg;
  assign running_o    = is_run;

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed bench for prog_mem with a per-cycle scoreboard.
// Each cycle the expected fetch response is pushed when inputs are driven and
// popped/compared one edge later; status outputs get explicit checks.
module tb_prog_mem;

  localparam int                W_INST = 28;
  localparam int                A      = 4;
  localparam int                DEPTH  = 16;
  localparam logic [W_INST-1:0] NOP    = '0;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              ld_valid_i = 1'b0;
  logic [W_INST-1:0] ld_data_i = '0;
  logic              ld_last_i = 1'b0;
  logic              ld_ready_o;
  logic              reload_i = 1'b0;
  logic              fetch_i = 1'b0;
  logic [A-1:0]      addr_i = '0;
  logic [W_INST-1:0] inst_o;
  logic              inst_valid_o;
  logic              oob_o;
  logic [A:0]        prog_len_o;
  logic              running_o;

  prog_mem #(.W_INST(W_INST), .A(A), .NOP(NOP)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_last_i    (ld_last_i),
    .ld_ready_o   (ld_ready_o),
    .reload_i     (reload_i),
    .fetch_i      (fetch_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .oob_o        (oob_o),
    .prog_len_o   (prog_len_o),
    .running_o    (running_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic              valid;
    logic              oob;
    logic [W_INST-1:0] inst;
  } exp_t;

  exp_t              sb_q[$];
  logic [W_INST-1:0] m_mem [DEPTH];
  int                m_len = 0;
  int                m_wp = 0;
  bit                m_run = 1'b0;
  logic [W_INST-1:0] m_last_inst = NOP;
  int                n_pass = 0;
  int                n_total = 0;
  logic [W_INST-1:0] words16 [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: predict this cycle's response, advance the model, then compare.
  task automatic tick();
    exp_t e;
    e.valid = !rst_i && m_run && fetch_i;
    e.oob   = e.valid && (int'(addr_i) >= m_len);
    if (rst_i)        e.inst = NOP;
    else if (e.valid) e.inst = e.oob ? NOP : m_mem[addr_i];
    else              e.inst = m_last_inst;
    m_last_inst = e.inst;
    sb_q.push_back(e);

    if (rst_i || reload_i) begin
      m_run = 1'b0; m_wp = 0; m_len = 0;
    end else if (ld_valid_i && !m_run) begin
      m_mem[m_wp] = ld_data_i;
      if (ld_last_i || m_wp == DEPTH - 1) begin
        m_run = 1'b1;
        m_len = m_wp + 1;
      end
      m_wp = (m_wp + 1) % DEPTH;
    end

    @(posedge clk_i);
    #1;
    e = sb_q.pop_front();
    chk("inst_valid_o", 32'(inst_valid_o), 32'(e.valid));
    chk("oob_o", 32'(oob_o), 32'(e.oob));
    chk("inst_o", 32'(inst_o), 32'(e.inst));
    $display("t=%0t fetch=%0b addr=%0d ld=%0b -> inst=0x%07h v=%0b oob=%0b len=%0d run=%0b rdy=%0b",
             $time, fetch_i, addr_i, ld_valid_i, inst_o, inst_valid_o, oob_o,
             prog_len_o, running_o, ld_ready_o);
  endtask

  task automatic load_word(input logic [W_INST-1:0] d, input logic last);
    ld_valid_i = 1'b1; ld_data_i = d; ld_last_i = last;
    tick();
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic fetch(input int a);
    fetch_i = 1'b1; addr_i = A'(a);
    tick();
    fetch_i = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int len, input logic run, input logic rdy);
    chk({tag, ".prog_len_o"}, 32'(prog_len_o), 32'(len));
    chk({tag, ".running_o"},  32'(running_o),  32'(run));
    chk({tag, ".ld_ready_o"}, 32'(ld_ready_o), 32'(rdy));
  endtask

  initial begin
    // Reset
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    chk_status("reset", 0, 1'b0, 1'b1);

    // Four-word program
    load_word(28'h64014EC, 1'b0);
    chk_status("load1", 0, 1'b0, 1'b1);
    load_word(28'hC004060, 1'b0);
    load_word(28'hC0960C0, 1'b0);
    load_word(28'h0480100, 1'b1);
    chk_status("load4", 4, 1'b1, 1'b0);

    // Back-to-back fetches, then an out-of-range one, then idle
    fetch(2);
    chk("f2.inst_o", 32'(inst_o), 32'h0C0960C0);
    fetch(0);
    chk("f0.inst_o", 32'(inst_o), 32'h064014EC);
    fetch(1);
    chk("f1.inst_o", 32'(inst_o), 32'h0C004060);
    fetch(3);
    chk("f3.inst_o", 32'(inst_o), 32'h00480100);
    fetch(7);
    chk("f7.oob_o", 32'(oob_o), 32'h1);
    tick();
    chk("idle.inst_valid_o", 32'(inst_valid_o), 32'h0);
    fetch(4);
    fetch(3);
    tick();
    chk("idle.inst_held", 32'(inst_o), 32'h00480100);

    // Load words while running are ignored
    load_word(28'h1111111, 1'b1);
    chk_status("run_ld_ignored", 4, 1'b1, 1'b0);
    fetch(0);

    // Reload with a concurrent fetch and a concurrent load word
    fetch_i = 1'b1; addr_i = 4'd1; reload_i = 1'b1;
    ld_valid_i = 1'b1; ld_data_i = 28'h2222222; ld_last_i = 1'b1;
    tick();
    fetch_i = 1'b0; reload_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0;
    chk("reload.inst_o", 32'(inst_o), 32'h0C004060);
    chk_status("reload", 0, 1'b0, 1'b1);
    fetch(0);

    // Sixteen words, never flagged last: fills the store and enters RUN
    for (int i = 0; i < DEPTH; i++) words16[i] = W_INST'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      load_word(words16[i], 1'b0);
      if (i == DEPTH - 2) chk_status("load15", 0, 1'b0, 1'b1);
    end
    chk_status("load16", 16, 1'b1, 1'b0);
    load_word(28'h3333333, 1'b0);
    chk_status("load17_ignored", 16, 1'b1, 1'b0);
    for (int i = DEPTH - 1; i >= 0; i--) fetch(i);
    fetch(0);
    chk("full.word0", 32'(inst_o), 32'(words16[0]));

    // Single-word program: stale data above it must read as NOP
    reload_i = 1'b1;
    tick();
    reload_i = 1'b0;
    load_word(28'hABCDEF0, 1'b1);
    chk_status("len1", 1, 1'b1, 1'b0);
    fetch(0);
    fetch(1);
    fetch(5);
    chk("stale.inst_o", 32'(inst_o), 32'(NOP));

    // Reset in the middle of a load, with a word and fetch presented
    reload_i = 1'b1;
    tick();
    reload_i = 1'b0;
    load_word(28'h4444444, 1'b0);
    load_word(28'h5555555, 1'b0);
    rst_i = 1'b1; ld_valid_i = 1'b1; ld_data_i = 28'h6666666; ld_last_i = 1'b1;
    fetch_i = 1'b1; addr_i = 4'd0;
    tick();
    rst_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0;
    chk_status("rst_midload", 0, 1'b0, 1'b1);
    fetch(0);
    chk("rst_midload.fetch_valid", 32'(inst_valid_o), 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
